// File: rtl/key_window_scheduler.sv
// key_window_scheduler: replays a loaded key table into a counter-locked FSM, one key per counter window
module key_window_scheduler #(
  parameter int KEY_W    = 14,
  parameter int NUM_KEYS = 4,
  parameter int WIN_LEN  = 8,
  parameter int CNT_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [1:0]       load_idx,
  input  logic [KEY_W-1:0] load_key,
  input  logic             start,
  input  logic             stop,
  input  logic             zeroize,
  output logic [KEY_W-1:0] key_out,
  output logic [1:0]       win_idx,
  output logic             active,
  output logic             start_err
);
  localparam int WIN_SH = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_KEYS*WIN_LEN-1);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0] table_q, table_d;
  logic [NUM_KEYS-1:0] valid_q, valid_d, wr_sel;
  logic start_err_q, start_err_d, wrap;
  always_comb begin
    wrap = cnt_q >= CNT_MAX;
    cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    win_idx = 2'(cnt_q >> WIN_SH);
    load_ready = state_q == IDLE;
    active = state_q == RUN;
    key_out = active ? table_q[win_idx] : '0;
    start_err = start_err_q;
    // out-of-range slots shift out of the one-hot and are silently dropped
    wr_sel = (load_ready && load_valid && !zeroize) ? NUM_KEYS'(1) << load_idx : '0;
    valid_d = zeroize ? '0 : valid_q | wr_sel;
    for (int i = 0; i < NUM_KEYS; i++)
      table_d[i] = zeroize ? '0 : wr_sel[i] ? load_key : table_q[i];
    // start is judged against the mask as it stood before this edge's load
    start_err_d = !zeroize && !stop && load_ready && start && !(&valid_q);
    state_d = (zeroize || stop)                     ? IDLE  :
              (state_q == IDLE && start && &valid_q) ? ARMED :
              (state_q == ARMED && wrap)             ? RUN   : state_q;
  end
  always_ff @(negedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      table_q     <= '0;
      valid_q     <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      table_q     <= table_d;
      valid_q     <= valid_d;
      start_err_q <= start_err_d;
    end
endmodule

// File: tb/tb_key_window_scheduler.sv
// tb_key_window_scheduler: directed vectors plus window-sequencing scenarios against a counter model
module tb_key_window_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic load_valid = 1'b0, start = 1'b0, stop = 1'b0, zeroize = 1'b0;
  logic [1:0] load_idx = '0;
  logic [13:0] load_key = '0;
  logic load_ready, active, start_err;
  logic [13:0] key_out;
  logic [1:0] win_idx;
  int n_vec = 0, n_err = 0, m_cnt = 0;
  logic [13:0] keys [4];
  typedef struct {
    logic lv; logic [1:0] li; logic [13:0] lk; logic st, sp, zz;
    logic [13:0] k; logic a, e, r;
  } vec_t;
  vec_t v [7];

  key_window_scheduler dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_idx(load_idx), .load_key(load_key), .start(start), .stop(stop),
    .zeroize(zeroize), .key_out(key_out), .win_idx(win_idx), .active(active),
    .start_err(start_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (model cnt %0d)", nm, act, exp, m_cnt);
    end
  endtask

  task automatic outs(logic [13:0] k, logic a, logic e, logic r);
    chk("key_out", 32'(key_out), 32'(k));
    chk("win_idx", 32'(win_idx), 32'(m_cnt >> 3));
    chk("active", 32'(active), 32'(a));
    chk("start_err", 32'(start_err), 32'(e));
    chk("load_ready", 32'(load_ready), 32'(r));
  endtask

  task automatic tick();
    @(negedge clk);
    m_cnt = rst ? 0 : (m_cnt == 31 ? 0 : m_cnt + 1);
    @(posedge clk);
  endtask

  task automatic load(int i, logic [13:0] k);
    load_valid = 1'b1; load_idx = 2'(i); load_key = k;
    tick();
    load_valid = 1'b0;
    outs(14'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic arm_and_wait();
    if (m_cnt == 31) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    outs(14'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40 && m_cnt != 0; i++) begin
      tick();
      if (m_cnt != 0) outs(14'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    keys[0] = 14'd1684; keys[1] = 14'd8450; keys[2] = 14'd51; keys[3] = 14'd4340;
    v[0] = '{1'b1, 2'd0, 14'd1684, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1};
    v[1] = '{1'b1, 2'd1, 14'd8450, 1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1};
    v[2] = '{1'b1, 2'd2, 14'd51,   1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1};
    v[3] = '{1'b0, 2'd0, 14'd0,    1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1};
    v[4] = '{1'b0, 2'd0, 14'd0,    1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1};
    v[5] = '{1'b1, 2'd3, 14'd4340, 1'b1, 1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1};
    v[6] = '{1'b0, 2'd0, 14'd0,    1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1};
    repeat (2) @(posedge clk);
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      load_valid = v[i].lv; load_idx = v[i].li; load_key = v[i].lk;
      start = v[i].st; stop = v[i].sp; zeroize = v[i].zz;
      tick();
      load_valid = 1'b0; start = 1'b0; stop = 1'b0; zeroize = 1'b0;
      outs(v[i].k, v[i].a, v[i].e, v[i].r);
    end
    // start sampled at cnt=5 must wait in ARMED for the wrap
    for (int i = 0; i < 40 && m_cnt != 5; i++) tick();
    arm_and_wait();
    outs(keys[0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 63; i++) begin
      tick();
      outs(keys[m_cnt >> 3], 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 40 && m_cnt != 13; i++) begin
      tick();
      outs(keys[m_cnt >> 3], 1'b1, 1'b0, 1'b0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    tick();
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    arm_and_wait();
    outs(14'd1684, 1'b1, 1'b0, 1'b0);
    // zeroize must win over a simultaneous load
    repeat (3) tick();
    zeroize = 1'b1; load_valid = 1'b1; load_idx = 2'd2; load_key = 14'h3FFF;
    tick();
    zeroize = 1'b0; load_valid = 1'b0;
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    load(0, keys[0]); load(1, keys[1]); load(3, keys[3]);
    start = 1'b1;
    tick();
    start = 1'b0;
    outs(14'd0, 1'b0, 1'b1, 1'b1);
    tick();
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    load(2, 14'd777);
    keys[2] = 14'd777;
    arm_and_wait();
    outs(keys[0], 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && m_cnt != 20; i++) begin
      tick();
      outs(keys[m_cnt >> 3], 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b1;
    #1;
    m_cnt = 0;
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    tick();
    outs(14'd0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      outs(14'd0, 1'b0, 1'b0, 1'b1);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    outs(14'd0, 1'b0, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/key_window_scheduler.md
Name: key_window_scheduler

Overview:
- Sequences the four time-windowed unlock keys into a counter-locked FSM benchmark, for example the lift controller family.
- Holds a loaded key table and keeps a replica of the target's 0..31 window counter.
- Drives the keyinput bus so that the key matching the current 8-cycle window is present whenever the locked FSM samples it.
- Sits between the test/config host and the locked FSM's keyinput pins.

Parameters:
KEY_W, 14, key width in bits; equals the locked FSM keyinput count
NUM_KEYS, 4, number of windows/keys per counter period
WIN_LEN, 8, cycles per window; power of two
CNT_W, 6, replica counter width; must hold NUM_KEYS*WIN_LEN-1

Ports:
clk  input  1  clock; all state updates on negedge, matching the locked FSM
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  host presents a key-table write
load_ready  output  1  scheduler accepts the write this edge
load_idx  input  2  table slot 0..NUM_KEYS-1
load_key  input  KEY_W  key value
start  input  1  request to begin driving keys
stop  input  1  return to IDLE; table kept
zeroize  input  1  clear table and valid mask, return to IDLE
key_out  output  KEY_W  to locked FSM keyinput0..KEY_W-1 (bit i = keyinput i)
win_idx  output  2  current window = cnt / WIN_LEN
active  output  1  key_out carries table keys
start_err  output  1  one-cycle pulse: start with incomplete table

Behaviour:
- Reset:
  - cnt=0, state=IDLE, table=0, valid_mask=0.
  - key_out=0, win_idx=0, active=0, start_err=0, load_ready=1.
- Replica counter:
  - Free-runs from reset regardless of state.
  - On negedge, cnt <= (cnt >= NUM_KEYS*WIN_LEN-1) ? 0 : cnt+1, so it stays cycle-aligned with the target counter, which shares rst and clk.
- win_idx = cnt[CNT_W-2:CNT_W-3] for the defaults (cnt>>3), combinational from the registered cnt.
- key_out:
  - In RUN: table[win_idx], combinational from registered cnt/state, stable across the whole window so the target's negedge samples the correct key.
  - In any other state: 0.
- States:
  - IDLE: load_ready=1. An accepted write sets table[load_idx] and valid_mask[load_idx]; rewrites overwrite the slot. On start: if valid_mask was all-ones before this edge, go to ARMED; otherwise stay in IDLE and pulse start_err for one cycle.
  - ARMED: load_ready=0, key_out=0. Go to RUN on the edge where cnt wraps to 0, so RUN always begins at window 0 and never part-way through a window.
  - RUN: load_ready=0, active=1. Stays in RUN through every counter wrap.
- Transitions out of ARMED/RUN:
  - stop: go to IDLE at the next edge; key_out=0 from then on.
  - zeroize: from any state, go to IDLE and clear the table and mask at the next edge.
- Priority at a single edge:
  - zeroize > stop > start > load.
  - Simultaneous load and start in IDLE: the load is committed, and start is evaluated against the pre-edge mask.
  - zeroize with load_valid: the load is dropped.
- load_idx >= NUM_KEYS: the write is ignored (unreachable with the defaults).
- rst asserted mid-RUN: immediately key_out=0, active=0, cnt=0, table cleared. The host must reload.
- Without asserted inputs: no output glitches within a window; key_out changes only just after negedges where win_idx or state changes.

Test Plan:
- Reset, then load slots 0..3 with 1684, 8450, 51, 4340, then start at cnt=5 -> ARMED until cnt wraps. At cnt=0 active=1. key_out=1684 for cnt 0-7, 8450 for 8-15, 51 for 16-23, 4340 for 24-31. Repeats on the next period.
- Load only slots 0,1,2, then start -> start_err high for exactly one cycle, state stays IDLE, key_out=0. Load slot 3, start again -> ARMED, no error.
- Connect to the locked lift FSM with the scheduler in RUN, drive x1=1 -> y1=1 and the FSM advances s1->s2. Control run with active forced 0 (key_out=0) -> target pr_state is forced to s7/s1/s3/s12 per window.
- In RUN at cnt=13, assert stop -> key_out=0 from the next edge, table retained. Start again -> resumes at the next cnt=0 with 1684.
- In RUN, assert zeroize with load_valid=1, load_idx=2, load_key=0x3FFF -> table all 0, valid_mask=0, IDLE. A later start gives start_err.
- Assert rst at cnt=20 during RUN -> key_out=0 and cnt=0 immediately. After release, cnt counts 0,1,2,... in lockstep with the target counter.
